// File: rtl/saturated_sub_accumulator_pkg.sv
// Shared saturating-arithmetic helpers and FSM state type for the
// saturating difference accumulator datapath.
package sat_arith_pkg;

  // Wide enough to hold any WIDTH+1 intermediate for practical widths.
  localparam int unsigned CALC_W = 64;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic                     clamped;
    logic signed [CALC_W-1:0] value;
  } sat_res_t;

  function automatic logic signed [CALC_W-1:0] sat_max(input int unsigned width);
    logic signed [CALC_W-1:0] one;
    one = {{(CALC_W-1){1'b0}}, 1'b1};
    return (one <<< (width - 1)) - one;
  endfunction

  function automatic logic signed [CALC_W-1:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  function automatic sat_res_t sat_clamp(input logic signed [CALC_W-1:0] x,
                                         input int unsigned width);
    sat_res_t res;
    res.clamped = 1'b0;
    res.value   = x;
    if (x > sat_max(width)) begin
      res.clamped = 1'b1;
      res.value   = sat_max(width);
    end else if (x < sat_min(width)) begin
      res.clamped = 1'b1;
      res.value   = sat_min(width);
    end
    return res;
  endfunction

endpackage

// File: rtl/saturated_sub_accumulator_subtractor.sv
// Combinational saturating subtractor: c = sat(a - b), clamped flags a clamp.
module saturated_subtractor
  import sat_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             clamped
);

  logic signed [WIDTH:0] diff;
  sat_res_t              res;
  logic                  unused_hi;

  always_comb begin
    diff    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    res     = sat_clamp(CALC_W'(diff), WIDTH);
    c       = res.value[WIDTH-1:0];
    clamped = res.clamped;
  end

  assign unused_hi = ^res.value[CALC_W-1:WIDTH];

endmodule

// File: rtl/saturated_sub_accumulator.sv
// Streaming saturating difference accumulator: folds LEN clamped differences
// into a clamped running sum and presents one result per vector.
module saturated_sub_accumulator
  import sat_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_sat
);

  localparam int unsigned      CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [WIDTH-1:0]  sum_q;
  logic              osat_q;

  logic [WIDTH-1:0]      diff;
  logic                  diff_clamped;
  logic signed [WIDTH:0] acc_sum;
  sat_res_t              acc_res;
  logic                  accept;
  logic                  last_beat;
  logic                  unused_hi;

  saturated_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a       (in_a),
    .b       (in_b),
    .c       (diff),
    .clamped (diff_clamped)
  );

  always_comb begin
    accept    = in_valid & (state_q == ACCUM);
    last_beat = (cnt_q == LAST);
    acc_sum   = {acc_q[WIDTH-1], acc_q} + {diff[WIDTH-1], diff};
    acc_res   = sat_clamp(CALC_W'(acc_sum), WIDTH);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    if (state_q == HOLD && out_ready) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      acc_d = acc_res.value[WIDTH-1:0];
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      sat_d = sat_q | diff_clamped | acc_res.clamped;
    end
  end

  assign unused_hi = ^acc_res.value[CALC_W-1:WIDTH];

  // The result registers load from the next-state values so the final beat's
  // contribution is captured on the same edge that enters HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      osat_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      case (state_q)
        ACCUM: begin
          if (accept && last_beat) begin
            state_q <= HOLD;
            sum_q   <= acc_d;
            osat_q  <= sat_d;
          end
        end
        HOLD: begin
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_sat   = osat_q;

endmodule

// File: tb/tb_saturated_sub_accumulator.sv
// Directed self-checking bench for saturated_sub_accumulator (WIDTH=8, LEN=4).
module tb_saturated_sub_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_sat;

  int unsigned tests = 0;
  int unsigned fails = 0;

  saturated_sub_accumulator #(.WIDTH(8), .LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic signed [7:0] a, input logic signed [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 8'hA5;
    in_b     = 8'h5A;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_sum !== 8'd0) begin fails++; $display("FAIL reset_out_sum got=%0d exp=0", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat(10, 3);
    beat(5, 7);
    beat(0, 0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    beat(-4, 1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_hold_ready got=%b exp=0", in_ready); end
    tests++; if ($signed(out_sum) !== 8'sd0) begin fails++; $display("FAIL basic_sum got=%0d exp=0", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
    consume();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_release got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_step_clamp();
    beat(-128, 1);
    repeat (3) beat(0, 0);
    tests++; if ($signed(out_sum) !== -8'sd128) begin fails++; $display("FAIL step_min_sum got=%0d exp=-128", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL step_min_sat got=%b exp=1", out_sat); end
    consume();
    beat(127, -1);
    repeat (3) beat(0, 0);
    tests++; if ($signed(out_sum) !== 8'sd127) begin fails++; $display("FAIL step_max_sum got=%0d exp=127", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL step_max_sat got=%b exp=1", out_sat); end
    consume();
  endtask

  task automatic test_acc_clamp();
    repeat (4) beat(100, 0);
    tests++; if ($signed(out_sum) !== 8'sd127) begin fails++; $display("FAIL acc_clamp_sum got=%0d exp=127", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL acc_clamp_sat got=%b exp=1", out_sat); end
    consume();
    repeat (4) beat(0, 0);
    tests++; if ($signed(out_sum) !== 8'sd0) begin fails++; $display("FAIL acc_clear_sum got=%0d exp=0", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL acc_clear_sat got=%b exp=0", out_sat); end
    consume();
  endtask

  task automatic test_backpressure();
    beat(1, 2);
    beat(3, 1);
    beat(0, 5);
    beat(2, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || $signed(out_sum) !== -8'sd4) begin
        fails++;
        $display("FAIL bp_hold_%0d got ready=%b valid=%b sum=%0d exp ready=0 valid=1 sum=-4",
                 i, in_ready, out_valid, $signed(out_sum));
      end
    end
    in_valid = 1'b0;
    consume();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    repeat (4) beat(2, 1);
    tests++; if ($signed(out_sum) !== 8'sd4 || out_sat !== 1'b0) begin fails++; $display("FAIL bp_next_vector got sum=%0d sat=%b exp sum=4 sat=0", $signed(out_sum), out_sat); end
    consume();
  endtask

  task automatic test_bubbles();
    logic signed [7:0] va [4];
    logic signed [7:0] vb [4];
    va = '{8'sd50, 8'sd60, -8'sd100, 8'sd20};
    vb = '{-8'sd30, -8'sd10, 8'sd50, 8'sd5};
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g <= i; g++) begin
        in_valid = 1'b0;
        in_a     = 8'sd127;
        in_b     = -8'sd128;
        @(posedge clk);
        #1;
      end
      if (i == 3) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bubble_early_valid got=%b exp=0", out_valid); end
      end
      beat(va[i], vb[i]);
    end
    tests++; if ($signed(out_sum) !== 8'sd14) begin fails++; $display("FAIL bubble_sum got=%0d exp=14", $signed(out_sum)); end
    tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL bubble_sat got=%b exp=1", out_sat); end
    consume();
  endtask

  task automatic test_reset_mid();
    beat(5, 0);
    beat(5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd0 || out_sat !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async got ready=%b valid=%b sum=%0d sat=%b exp 1/0/0/0",
               in_ready, out_valid, $signed(out_sum), out_sat);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) beat(1, 0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midreset_valid got=%b exp=1", out_valid); end
    tests++; if ($signed(out_sum) !== 8'sd4 || out_sat !== 1'b0) begin fails++; $display("FAIL midreset_sum got sum=%0d sat=%b exp sum=4 sat=0", $signed(out_sum), out_sat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step_clamp();
    test_acc_clamp();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
